train_step_prod_accum: RTL and testbench
========================================

Name: train_step_prod_accum

Overview:
- Streaming accumulator directly downstream of the 8s x 2s -> 10-bit signed product multiplier in the BNN train_step datapath.
- Consumes one signed product per accepted beat and sums VEC_LEN products, or fewer if in_last ends the vector early, into a saturating signed accumulator.
- Emits the dot-product sum, its binarized sign and a saturation flag on a valid/ready output.
- Feeds the binarization / weight-update stage.

Parameters:
- PROD_WIDTH, 10, signed product width from the multiplier.
- ACC_WIDTH, 18, signed accumulator/output width; must be >= PROD_WIDTH.
- VEC_LEN, 64, products per vector; must be >= 1.
- CNT_WIDTH, 7, term counter width; must satisfy 2^CNT_WIDTH > VEC_LEN.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush, highest priority after reset.
- in_prod  in  PROD_WIDTH  signed product.
- in_last  in  1  marks the final product of the vector; qualified by in_valid.
- in_valid  in  1  product valid.
- in_ready  out  1  block can accept a product.
- out_sum  out  ACC_WIDTH  signed accumulated sum.
- out_sign  out  1  binarized result: 1 when out_sum >= 0.
- out_sat  out  1  saturation occurred at least once in this vector.
- out_count  out  CNT_WIDTH  number of products summed.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (ap_rst_n low, async):
  - state = IDLE; acc = 0; cnt = 0; sat = 0.
  - out_sum = 0, out_sign = 0, out_sat = 0, out_count = 0, out_valid = 0, busy = 0.
  - Reset mid-vector discards the partial sum.
- States:
  - IDLE: no vector in progress.
  - ACC: accumulating a vector.
  - HOLD: result presented on the output.
- Handshake definitions:
  - Input accept: acc_in = in_valid && in_ready.
  - Output handshake: out_valid && out_ready.
- in_ready is combinational:
  - 1 in IDLE and ACC.
  - In HOLD, in_ready = out_ready. This lets the first beat of the next vector be accepted in the same cycle the result is taken.
- Accumulation arithmetic:
  - Products are sign-extended to ACC_WIDTH+1.
  - The sum is computed at ACC_WIDTH+1 bits, then clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Any clamp sets sat, which is sticky until the next vector starts.
- First beat (acc_in in IDLE, or in HOLD during an output handshake):
  - acc = sext(in_prod); cnt = 1; sat = 0.
- Subsequent beats (acc_in in ACC):
  - acc = sat_add(acc, in_prod); cnt = cnt + 1.
- End of vector: the accepted beat completes the vector when in_last = 1 or the new cnt == VEC_LEN.
  - On that edge the final acc/cnt/sat are registered to the outputs, out_valid = 1, state = HOLD.
  - Latency: out_valid rises the cycle after the last beat is accepted.
  - in_last on the first beat, or VEC_LEN == 1, gives a single-term vector.
- Without end of vector: state = ACC.
- in_valid low in ACC: state and acc are held; no timeout.
- HOLD:
  - out_sum, out_sign, out_sat and out_count stay stable while out_valid = 1 and out_ready = 0.
  - On output handshake with no acc_in: out_valid = 0, state = IDLE.
  - On output handshake with acc_in: first-beat rule applies; next state is ACC, or HOLD again with new outputs if that beat ends its vector.
- out_sign = ~out_sum[ACC_WIDTH-1]; updated together with out_sum.
- clear = 1 (sync):
  - state = IDLE; acc = 0; cnt = 0; sat = 0; out_valid = 0.
  - Any pending result is dropped.
  - Registered out_sum/out_count keep their last values (don't-care while out_valid = 0).
  - Any input beat presented that cycle is ignored, i.e. not accumulated.
- Counter never wraps: the end-of-vector condition forces the transition at VEC_LEN.
- in_prod and in_last are ignored when in_valid = 0.

Test Plan:
- Full vector: 64 beats of in_prod = +3, in_valid held high.
  - out_valid rises 1 cycle after the 64th accept; out_sum = 192, out_sign = 1, out_count = 64, out_sat = 0.
- Early end: products -10, -10, -10, -10, +5 with in_last on the 5th.
  - out_sum = -35, out_sign = 0, out_count = 5.
  - Single beat in_prod = 0 with in_last gives out_sum = 0, out_sign = 1, out_count = 1.
- Backpressure: result pending, out_ready low for 10 cycles.
  - Outputs stable and in_ready = 0 throughout.
  - Then out_ready = 1 with in_valid = 1 and in_prod = +7: result taken and +7 accepted as the first beat of the next vector in the same cycle; the next result starts from 7.
- Saturation with ACC_WIDTH = 10, VEC_LEN = 4:
  - in_prod = +256 x4 gives out_sum = 511, out_sat = 1.
  - Next vector -256 x4 gives out_sum = -512, out_sat = 1.
  - Next vector +1 x4 gives out_sum = 4, out_sat = 0.
- Reset/clear:
  - ap_rst_n pulsed low mid-cycle after 30 beats: all outputs 0 immediately.
  - A following 64 x (+1) vector gives out_sum = 64.
  - clear asserted in HOLD drops out_valid next edge and returns to IDLE; a beat presented during clear is not counted.
- Random: 1000 vectors with random products (-256..+256), random in_last, random in_valid/out_ready.
  - Results match the reference model sum and count exactly; no beat lost or duplicated.

Source files
------------

// File: rtl/train_step_prod_accum.sv
// Streaming saturating accumulator for the BNN train_step datapath.
// Sums up to VEC_LEN signed products per vector (in_last may end it early)
// and presents sum, binarized sign, sticky saturation flag and term count
// on a valid/ready output.
// Ports:
//   ap_clk, ap_rst_n    clock (rising edge), async active-low reset
//   clear               synchronous flush of state and pending result
//   in_prod/in_last     product beat and end-of-vector marker
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   out_sum/out_sign    accumulated sum and its sign bit (1 when sum >= 0)
//   out_sat/out_count   saturation flag for the vector and products summed
//   out_valid/out_ready output handshake
//   busy                a vector is in progress or a result is pending
module train_step_prod_accum #(
  parameter int unsigned PROD_WIDTH = 10,
  parameter int unsigned ACC_WIDTH  = 18,
  parameter int unsigned VEC_LEN    = 64,
  parameter int unsigned CNT_WIDTH  = 7
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  clear,
  input  logic [PROD_WIDTH-1:0] in_prod,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic                  out_sign,
  output logic                  out_sat,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;
  localparam logic [SUM_WIDTH-1:0] ACC_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [SUM_WIDTH-1:0] ACC_MIN = {2'b11, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   sat_q, sat_d;
  logic [ACC_WIDTH-1:0]   out_sum_q, out_sum_d;
  logic                   out_sign_q, out_sign_d;
  logic                   out_sat_q, out_sat_d;
  logic [CNT_WIDTH-1:0]   out_count_q, out_count_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;

  logic                   out_hs;
  logic                   acc_in;
  logic                   first_beat;
  logic [SUM_WIDTH-1:0]   prod_ext;
  logic [SUM_WIDTH-1:0]   base_ext;
  logic [SUM_WIDTH-1:0]   sum_wide;
  logic                   ovf_pos;
  logic                   ovf_neg;
  logic [ACC_WIDTH-1:0]   acc_next;
  logic                   sat_next;
  logic [CNT_WIDTH-1:0]   cnt_next;
  logic                   vec_end;

  // In HOLD the next vector may start only in the cycle the result is taken.
  assign in_ready = (state_q != ST_HOLD) || out_ready;
  assign out_hs   = out_valid_q && out_ready;
  // clear wins over any beat presented in the same cycle.
  assign acc_in   = in_valid && in_ready && !clear;
  // Outside ACC an accepted beat always opens a new vector.
  assign first_beat = (state_q != ST_ACC);

  // One-bit-wider sum; top two bits disagreeing means the clamp engages.
  assign prod_ext = {{(SUM_WIDTH-PROD_WIDTH){in_prod[PROD_WIDTH-1]}}, in_prod};
  assign base_ext = first_beat ? '0 : {acc_q[ACC_WIDTH-1], acc_q};
  assign sum_wide = base_ext + prod_ext;
  assign ovf_pos  = !sum_wide[SUM_WIDTH-1] &&  sum_wide[SUM_WIDTH-2];
  assign ovf_neg  =  sum_wide[SUM_WIDTH-1] && !sum_wide[SUM_WIDTH-2];

  always_comb begin
    acc_next = sum_wide[ACC_WIDTH-1:0];
    if (ovf_pos) begin
      acc_next = ACC_MAX[ACC_WIDTH-1:0];
    end else if (ovf_neg) begin
      acc_next = ACC_MIN[ACC_WIDTH-1:0];
    end
  end

  assign sat_next = (first_beat ? 1'b0 : sat_q) || ovf_pos || ovf_neg;
  assign cnt_next = first_beat ? CNT_WIDTH'(1) : cnt_q + CNT_WIDTH'(1);
  assign vec_end  = in_last || (cnt_next == CNT_WIDTH'(VEC_LEN));

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (acc_in) begin
      state_d = vec_end ? ST_HOLD : ST_ACC;
    end else if ((state_q == ST_HOLD) && out_hs) begin
      state_d = ST_IDLE;
    end
  end

  // Datapath and output next values.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_sum_d   = out_sum_q;
    out_sign_d  = out_sign_q;
    out_sat_d   = out_sat_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    busy_d      = (state_d != ST_IDLE);
    if (clear) begin
      acc_d       = '0;
      cnt_d       = '0;
      sat_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (out_hs) begin
        out_valid_d = 1'b0;
      end
      if (acc_in) begin
        acc_d = acc_next;
        cnt_d = cnt_next;
        sat_d = sat_next;
        if (vec_end) begin
          out_sum_d   = acc_next;
          out_sign_d  = ~acc_next[ACC_WIDTH-1];
          out_sat_d   = sat_next;
          out_count_d = cnt_next;
          out_valid_d = 1'b1;
        end
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_sum_q   <= '0;
      out_sign_q  <= 1'b0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_sum_q   <= out_sum_d;
      out_sign_q  <= out_sign_d;
      out_sat_q   <= out_sat_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_sum   = out_sum_q;
  assign out_sign  = out_sign_q;
  assign out_sat   = out_sat_q;
  assign out_count = out_count_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_train_step_prod_accum.sv
// Self-checking bench for train_step_prod_accum: directed vectors, a
// narrow-accumulator instance for saturation, and randomized traffic
// scored against a queue-based reference model.
module tb_train_step_prod_accum;

  localparam int unsigned PW  = 10;
  localparam int unsigned AW  = 18;
  localparam int unsigned VL  = 64;
  localparam int unsigned CW  = 7;
  localparam int unsigned SAW = 10;
  localparam int unsigned SVL = 4;
  localparam int unsigned SCW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;

  logic          clear = 1'b0;
  logic [PW-1:0] in_prod = '0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] out_sum;
  logic          out_sign;
  logic          out_sat;
  logic [CW-1:0] out_count;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;

  logic           s_clear = 1'b0;
  logic [PW-1:0]  s_prod = '0;
  logic           s_last = 1'b0;
  logic           s_valid = 1'b0;
  logic           s_in_ready;
  logic [SAW-1:0] s_sum;
  logic           s_sign;
  logic           s_sat;
  logic [SCW-1:0] s_count;
  logic           s_out_valid;
  logic           s_out_ready = 1'b0;
  logic           s_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  train_step_prod_accum #(
    .PROD_WIDTH(PW), .ACC_WIDTH(AW), .VEC_LEN(VL), .CNT_WIDTH(CW)
  ) u_dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .clear(clear),
    .in_prod(in_prod), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .out_sum(out_sum), .out_sign(out_sign),
    .out_sat(out_sat), .out_count(out_count), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  train_step_prod_accum #(
    .PROD_WIDTH(PW), .ACC_WIDTH(SAW), .VEC_LEN(SVL), .CNT_WIDTH(SCW)
  ) u_sat (
    .ap_clk(clk), .ap_rst_n(rst_n), .clear(s_clear),
    .in_prod(s_prod), .in_last(s_last), .in_valid(s_valid),
    .in_ready(s_in_ready), .out_sum(s_sum), .out_sign(s_sign),
    .out_sat(s_sat), .out_count(s_count), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .busy(s_busy)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: accepted beats build the current vector; completed
  // vectors queue up until the consumer takes them.
  localparam int ACC_MAX = (1 << (AW - 1)) - 1;
  localparam int ACC_MIN = -(1 << (AW - 1));
  int cur_sum = 0;
  int cur_cnt = 0;
  bit cur_sat = 1'b0;
  int exp_sum_q[$];
  int exp_cnt_q[$];
  bit exp_sat_q[$];
  int n_results = 0;

  always @(negedge clk) begin
    if (!rst_n || clear) begin
      cur_sum = 0;
      cur_cnt = 0;
      cur_sat = 1'b0;
      exp_sum_q.delete();
      exp_cnt_q.delete();
      exp_sat_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_sum_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          int es;
          int ec;
          bit ex;
          es = exp_sum_q.pop_front();
          ec = exp_cnt_q.pop_front();
          ex = exp_sat_q.pop_front();
          check("model_sum", longint'($signed(out_sum)), es);
          check("model_count", out_count, ec);
          check("model_sat", out_sat, ex);
          check("model_sign", out_sign, (es >= 0) ? 1 : 0);
          n_results++;
        end
      end
      if (in_valid && in_ready) begin
        cur_sum = cur_sum + int'($signed(in_prod));
        if (cur_sum > ACC_MAX) begin
          cur_sum = ACC_MAX;
          cur_sat = 1'b1;
        end else if (cur_sum < ACC_MIN) begin
          cur_sum = ACC_MIN;
          cur_sat = 1'b1;
        end
        cur_cnt++;
        if (in_last || cur_cnt == VL) begin
          exp_sum_q.push_back(cur_sum);
          exp_cnt_q.push_back(cur_cnt);
          exp_sat_q.push_back(cur_sat);
          cur_sum = 0;
          cur_cnt = 0;
          cur_sat = 1'b0;
        end
      end
    end
  end

  // Present one beat and return just after the edge that accepts it.
  task automatic send(input int p, input bit last);
    int guard;
    bit done;
    guard = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_prod = PW'(p);
    in_last = last;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (!done && guard > 100) begin
        check("send_timeout", 0, 1);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("take_valid_drops", out_valid, 0);
  endtask

  initial begin
    int sat_val[3];
    int sat_sum[3];
    int sat_flag[3];
    int base;
    int cycles;
    int v;

    sat_val  = '{256, -256, 1};
    sat_sum  = '{511, -512, 4};
    sat_flag = '{1, 1, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_sum", out_sum, 0);
    check("rst_sign", out_sign, 0);
    check("rst_sat", out_sat, 0);
    check("rst_count", out_count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full vector of +3
    for (int i = 0; i < 63; i++) send(3, 1'b0);
    check("full_not_early", out_valid, 0);
    check("full_busy", busy, 1);
    send(3, 1'b0);
    check("full_valid", out_valid, 1);
    check("full_sum", longint'($signed(out_sum)), 192);
    check("full_sign", out_sign, 1);
    check("full_count", out_count, 64);
    check("full_sat", out_sat, 0);
    take();

    // Early end
    for (int i = 0; i < 4; i++) send(-10, 1'b0);
    send(5, 1'b1);
    check("early_valid", out_valid, 1);
    check("early_sum", longint'($signed(out_sum)), -35);
    check("early_sign", out_sign, 0);
    check("early_count", out_count, 5);
    take();

    // Single zero beat
    send(0, 1'b1);
    check("single_sum", longint'($signed(out_sum)), 0);
    check("single_sign", out_sign, 1);
    check("single_count", out_count, 1);
    take();

    // Backpressure, then take-and-accept in the same cycle
    send(2, 1'b0);
    send(2, 1'b0);
    send(2, 1'b1);
    in_valid = 1'b1;
    in_prod = PW'(7);
    in_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
      check("bp_sum", longint'($signed(out_sum)), 6);
      check("bp_count", out_count, 3);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("bp_taken", out_valid, 0);
    check("bp_busy", busy, 1);
    send(1, 1'b1);
    check("bp_next_sum", longint'($signed(out_sum)), 8);
    check("bp_next_count", out_count, 2);
    take();

    // Saturation on the narrow instance, back-to-back vectors
    s_valid = 1'b1;
    s_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int b = 0; b < SVL; b++) begin
        s_prod = PW'(sat_val[k]);
        @(posedge clk);
        #1;
      end
      check("sat_valid", s_out_valid, 1);
      check("sat_sum", longint'($signed(s_sum)), sat_sum[k]);
      check("sat_flag", s_sat, sat_flag[k]);
      check("sat_count", s_count, SVL);
      check("sat_sign", s_sign, (sat_sum[k] >= 0) ? 1 : 0);
    end
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    check("sat_drained", s_out_valid, 0);
    s_out_ready = 1'b0;

    // Clear while holding a result
    send(4, 1'b1);
    clear = 1'b1;
    in_valid = 1'b1;
    in_prod = PW'(100);
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    check("clr_hold_valid", out_valid, 0);
    check("clr_hold_busy", busy, 0);

    // Clear mid-vector with a beat presented
    send(2, 1'b0);
    send(2, 1'b0);
    clear = 1'b1;
    in_valid = 1'b1;
    in_prod = PW'(100);
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    check("clr_acc_busy", busy, 0);
    send(5, 1'b1);
    check("clr_next_sum", longint'($signed(out_sum)), 5);
    check("clr_next_count", out_count, 1);
    take();

    // Async reset mid-vector
    for (int i = 0; i < 30; i++) send(1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_sum", out_sum, 0);
    check("arst_sign", out_sign, 0);
    check("arst_count", out_count, 0);
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) send(1, 1'b0);
    check("arst_next_sum", longint'($signed(out_sum)), 64);
    check("arst_next_count", out_count, 64);
    take();

    // Randomized traffic
    base = n_results;
    cycles = 0;
    while ((n_results - base) < 1000 && cycles < 70000) begin
      in_valid = ($urandom_range(0, 9) < 7);
      v = int'($urandom_range(0, 512)) - 256;
      in_prod = PW'(v);
      in_last = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
      cycles++;
    end
    check("rand_vectors_done", ((n_results - base) >= 1000) ? 1 : 0, 1);
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rand_no_pending", exp_sum_q.size(), 0);
    check("rand_drained", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
